// File: rtl/mem_pkg.sv
// Data-memory encodings, responder FSM states and byte-lane helpers.
// The mem_rd/mem_wr encodings are shared with the core's control decode.
package mem_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LW   = 3'b001;
  localparam logic [2:0] RD_LH   = 3'b010;
  localparam logic [2:0] RD_LHU  = 3'b011;
  localparam logic [2:0] RD_LB   = 3'b100;
  localparam logic [2:0] RD_LBU  = 3'b101;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SW   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SB   = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic req_error(input logic [2:0] rd, input logic [1:0] wr,
                                     input logic [1:0] a);
    logic e;
    e = ((rd != RD_NONE) && (wr != WR_NONE)) || (rd == 3'b110) || (rd == 3'b111);
    if ((rd == RD_LW) || (wr == WR_SW))
      e = e | (a != 2'b00);
    if ((rd == RD_LH) || (rd == RD_LHU) || (wr == WR_SH))
      e = e | a[0];
    return e;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] wr, input logic [1:0] a);
    logic [3:0] be;
    case (wr)
      WR_SW:   be = 4'b1111;
      WR_SH:   be = a[1] ? 4'b1100 : 4'b0011;
      WR_SB:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across lanes; the byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [1:0] wr, input logic [31:0] d);
    logic [31:0] r;
    case (wr)
      WR_SB:   r = {4{d[7:0]}};
      WR_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] rd, input logic [31:0] w,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (rd)
      RD_LW:   r = w;
      RD_LH:   r = {{16{h[15]}}, h};
      RD_LHU:  r = {16'h0000, h};
      RD_LB:   r = {{24{b[7]}}, b};
      RD_LBU:  r = {24'h000000, b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++)
        if (we[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte/half/word access with load extension and misalignment errors.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_rd,
  input  logic [1:0]  mem_wr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        rd_q;
  logic [1:0]        wr_q;
  logic [31:0]       wdata_q;
  logic              ld_ok;

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W+1:0] cur_addr;
  logic [2:0]        cur_rd;
  logic [1:0]        cur_wr;
  logic [31:0]       cur_wdata;
  logic              cur_err;
  logic [31:0]       ram_q;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && (state == IDLE);

  // With zero latency the RAM access happens on the accept edge, so it must
  // see the live inputs rather than the capture registers.
  assign cur_addr  = (state == IDLE) ? addr[ADDR_W+1:0] : addr_q;
  assign cur_rd    = (state == IDLE) ? mem_rd : rd_q;
  assign cur_wr    = (state == IDLE) ? mem_wr : wr_q;
  assign cur_wdata = (state == IDLE) ? wdata  : wdata_q;
  assign cur_err   = req_error(cur_rd, cur_wr, cur_addr[1:0]);

  assign enter_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0));

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (enter_resp),
    .we    (cur_err ? 4'b0000 : store_be(cur_wr, cur_addr[1:0])),
    .idx   (cur_addr[ADDR_W+1:2]),
    .wdata (store_data(cur_wr, cur_wdata)),
    .rdata (ram_q)
  );

  assign rdata = ld_ok ? load_extend(rd_q, ram_q, addr_q[1:0]) : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      rd_q       <= RD_NONE;
      wr_q       <= WR_NONE;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ld_ok      <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      resp_err   <= enter_resp && cur_err;
      ld_ok      <= enter_resp && !cur_err && (cur_rd != RD_NONE);
      case (state)
        IDLE: if (accept) begin
          addr_q  <= addr[ADDR_W+1:0];
          rd_q    <= mem_rd;
          wr_q    <= mem_wr;
          wdata_q <= wdata;
          if (LATENCY == 0) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: one LATENCY=2 instance and
// one LATENCY=0 / ADDR_W=4 instance sharing the request bus.
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v2 = 1'b0, v0 = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  mem_rd = 3'b000;
  logic [1:0]  mem_wr = 2'b00;

  logic        rdy2, rv2, err2, busy2;
  logic [31:0] rd2;
  logic        rdy0, rv0, err0, busy0;
  logic [31:0] rd0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .addr(addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wdata(wdata), .resp_valid(rv2),
    .rdata(rd2), .resp_err(err2), .busy(busy2)
  );

  dmem_responder #(.ADDR_W(4), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .addr(addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wdata(wdata), .resp_valid(rv0),
    .rdata(rd0), .resp_err(err0), .busy(busy0)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit l0, input logic [2:0] rd, input logic [1:0] wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input string tag);
    exp_t e;
    int   n, low;
    bit   seen;
    e.d = exp_d; e.e = exp_e; e.lat = l0 ? 1 : 3;
    sb_q.push_back(e);
    @(negedge clk);
    check({tag, "_ready"}, l0 ? rdy0 : rdy2, 1);
    check({tag, "_rv_idle"}, l0 ? rv0 : rv2, 0);
    addr = a; mem_rd = rd; mem_wr = wr; wdata = d;
    if (l0) v0 = 1'b1; else v2 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v2 = 1'b0;
    addr = $urandom; wdata = $urandom;
    mem_rd = 3'($urandom_range(0, 7)); mem_wr = 2'($urandom_range(0, 3));
    n = 0; low = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (!(l0 ? rdy0 : rdy2)) low++;
      if (l0 ? rv0 : rv2) seen = 1;
    end
    e = sb_q.pop_front();
    check({tag, "_seen"}, 32'(seen), 1);
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_rdy_low"}, low, e.lat);
    check({tag, "_busy"}, l0 ? busy0 : busy2, 1);
    check({tag, "_rdata"}, l0 ? rd0 : rd2, e.d);
    check({tag, "_err"}, l0 ? err0 : err2, 32'(e.e));
  endtask

  initial begin
    int rv_cnt;
    #1;
    check("rst_ready", rdy2, 1);
    check("rst_busy", busy2, 0);
    check("rst_rv", rv2, 0);
    check("rst_rdata", rd2, 0);
    check("rst_err", err2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    req(0, RD_NONE, WR_SW, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw10");
    req(0, RD_LW,   WR_NONE, 32'h10, 0, 32'hDEADBEEF, 0, "lw10");
    req(0, RD_LB,   WR_NONE, 32'h13, 0, 32'hFFFFFFDE, 0, "lb13");
    req(0, RD_LBU,  WR_NONE, 32'h13, 0, 32'h000000DE, 0, "lbu13");
    req(0, RD_LH,   WR_NONE, 32'h12, 0, 32'hFFFFDEAD, 0, "lh12");
    req(0, RD_LHU,  WR_NONE, 32'h10, 0, 32'h0000BEEF, 0, "lhu10");
    req(0, RD_NONE, WR_SB, 32'h11, 32'h55, 32'h0, 0, "sb11");
    req(0, RD_LW,   WR_NONE, 32'h10, 0, 32'hDEAD55EF, 0, "lw_sb");
    req(0, RD_NONE, WR_SH, 32'h12, 32'h1234, 32'h0, 0, "sh12");
    req(0, RD_LW,   WR_NONE, 32'h10, 0, 32'h123455EF, 0, "lw_sh");
    req(0, RD_LW,   WR_NONE, 32'h11, 0, 32'h0, 1, "lw_mis");
    req(0, RD_NONE, WR_SH, 32'h13, 32'hFFFF, 32'h0, 1, "sh_mis");
    req(0, RD_LW,   WR_SW, 32'h10, 32'h0, 32'h0, 1, "rd_wr");
    req(0, 3'b110,  WR_NONE, 32'h10, 0, 32'h0, 1, "rd_ill");
    req(0, RD_NONE, WR_NONE, 32'h10, 0, 32'h0, 0, "noop");
    req(0, RD_LW,   WR_NONE, 32'h10, 0, 32'h123455EF, 0, "lw_after_err");

    req(1, RD_NONE, WR_SW, 32'h40, 32'hA5A5A5A5, 32'h0, 0, "l0_sw40");
    req(1, RD_LW,   WR_NONE, 32'h00, 0, 32'hA5A5A5A5, 0, "l0_lw00");
    req(1, RD_LB,   WR_NONE, 32'h03, 0, 32'hFFFFFFA5, 0, "l0_lb03");

    // Reset during WAIT of a store: nothing may be committed or answered.
    req(0, RD_NONE, WR_SW, 32'h20, 32'h0, 32'h0, 0, "pre20");
    @(negedge clk);
    addr = 32'h20; mem_rd = RD_NONE; mem_wr = WR_SW; wdata = 32'h1; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    check("mid_busy", busy2, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", rdy2, 1);
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_rv", rv2, 0);
    check("mid_rst_rdata", rd2, 0);
    check("mid_rst_err", err2, 0);
    rv_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv2) rv_cnt++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rv2) rv_cnt++;
    end
    check("mid_rst_no_resp", rv_cnt, 0);
    req(0, RD_LW, WR_NONE, 32'h20, 0, 32'h0, 0, "lw20_after_rst");

    // A request offered while busy must be ignored, not queued.
    @(negedge clk);
    addr = 32'h10; mem_rd = RD_LW; mem_wr = WR_NONE; v2 = 1'b1;
    @(posedge clk);
    #1;
    mem_rd = RD_NONE; mem_wr = WR_SW; wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    v2 = 1'b0;
    rv_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv2) rv_cnt++;
    end
    check("busy_ignore_resp_count", rv_cnt, 1);
    req(0, RD_LW, WR_NONE, 32'h10, 0, 32'h123455EF, 0, "lw_not_queued");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the CPU data-memory interface: accepts one load/store request at a time from the core's MemRead/MemWr decode, applies a programmable wait-state latency, and performs byte/half/word accesses on an internal word-organised RAM. It returns extended load data and an error flag, and provides a `busy` stall indication so the core can be held during wait states. It sits beside the datapath as its data-memory slave.

## Interface

Parameters:
- `ADDR_W`, default 10: word-address bits; RAM depth is 2^ADDR_W words of 32 bits.
- `LATENCY`, default 2: wait-state cycles, legal range 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `addr` in 32: byte address.
- `mem_rd` in 3: load type. 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 illegal.
- `mem_wr` in 2: store type. 00 none, 01 sw, 10 sh, 11 sb.
- `wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response strobe.
- `rdata` out 32: extended load data.
- `resp_err` out 1: request rejected; valid with `resp_valid`.
- `busy` out 1: high from accept through the RESP cycle.

## Operation

- Accept occurs on the edge where `req_valid && req_ready`. `addr`, `mem_rd`, `mem_wr` and `wdata` are captured at accept; the inputs are don't-care afterwards.
- FSM states and transitions:
  - IDLE → WAIT on accept when LATENCY>0; IDLE → RESP on accept when LATENCY=0.
  - WAIT counts LATENCY cycles, then → RESP.
  - RESP lasts one cycle, then → IDLE.
- `req_ready` = (state==IDLE). `busy` = (state!=IDLE).
- Error conditions: `mem_rd`≠0 and `mem_wr`≠0 together; `mem_rd` in {110,111}; word access with addr[1:0]≠0; half access with addr[0]≠0.
  - On error there is no RAM write, `rdata`=0 and `resp_err`=1.
- A request with both fields zero is a no-op. It is acknowledged with `resp_err`=0 and `rdata`=0.
- Byte lanes are little-endian: lane k = bits [8k+7:8k] and is selected by addr[1:0].
  - sb writes `wdata[7:0]` to lane addr[1:0].
  - sh writes `wdata[15:0]` to lanes {2·addr[1]+1, 2·addr[1]}.
  - sw writes all four lanes.
- Loads: lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.

## Timing

- The RAM write and the RAM read happen at the edge entering RESP. `rdata`/`resp_err` are registered there, and `resp_valid`=1 for exactly the RESP cycle.
- Response cycle = accept cycle + LATENCY + 1. Maximum throughput is one request per LATENCY+2 cycles.
- A store followed by a load to the same word returns the new data.
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `resp_valid`=0, `rdata`=0, `resp_err`=0, wait counter 0.
  - RAM contents are not reset.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and no response is issued.
  - A store not yet committed (still in WAIT) is discarded.
- `req_valid` while not ready is ignored. It is not queued.

## Structure

- Shared package `mem_pkg` holds:
  - the `mem_rd`/`mem_wr` encodings, which the Control decode also uses;
  - the FSM state enum {IDLE, WAIT, RESP};
  - the lane-select/extension helper functions.
- Sub-module `dmem_ram`: single-port, 4-bit byte-enable write, registered read, depth 2^ADDR_W.
- `dmem_responder` contains the FSM, wait counter, request capture registers, error check, lane steering and load extension.

## Test plan

- LATENCY=2: sw addr 0x10 data 0xDEADBEEF, then lw 0x10. Expect `resp_valid` 3 cycles after each accept, `rdata`=0xDEADBEEF, `resp_err`=0, `req_ready` low for 3 cycles.
- After the sw above, lb 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x12 → 0xFFFFDEAD; lhu 0x10 → 0x0000BEEF.
- sb 0x11 data 0x55, then lw 0x10 → 0xDEAD55EF. sh 0x12 data 0x1234, then lw → 0x123455EF.
- lw 0x11, sh 0x13, and `mem_rd`=001 with `mem_wr`=01 together → `resp_err`=1, `rdata`=0. A following lw 0x10 shows the word unchanged.
- LATENCY=0, ADDR_W=4: sw addr 0x40 data 0xA5A5A5A5, then lw 0x00. The response comes 1 cycle after accept and returns 0xA5A5A5A5 (wrap).
- Assert `rst` during WAIT of sw 0x20 data 0x1. Expect no `resp_valid`, all outputs at reset values, and after release a lw 0x20 does not return 0x1 (RAM pre-filled with 0 beforehand).
